// File: rtl/i2c_fifo_pair_if.sv
// rtl/i2c_fifo_pair_if.sv - TX/RX buffer pair signal bundle with driver/buffer modports
interface i2c_fifo_pair_if #(
  parameter int TX_DW = 10,
  parameter int RX_DW = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             tx_flush;
  logic             tx_wr;
  logic [TX_DW-1:0] tx_din;
  logic             tx_rd;
  logic [TX_DW-1:0] tx_dout;
  logic             tx_empty;
  logic             tx_full;
  logic [AW:0]      tx_ocy;
  logic [AW:0]      tx_thr;
  logic             tx_low;
  logic             rx_flush;
  logic             rx_wr;
  logic [RX_DW-1:0] rx_din;
  logic             rx_rd;
  logic [RX_DW-1:0] rx_dout;
  logic             rx_empty;
  logic             rx_full;
  logic [AW:0]      rx_ocy;
  logic [AW:0]      rx_thr;
  logic             rx_high;
  logic [3:0]       err_clr;
  logic [3:0]       err;

  modport master (
    output tx_flush, tx_wr, tx_din, tx_rd, tx_thr,
    output rx_flush, rx_wr, rx_din, rx_rd, rx_thr, err_clr,
    input  tx_dout, tx_empty, tx_full, tx_ocy, tx_low,
    input  rx_dout, rx_empty, rx_full, rx_ocy, rx_high, err
  );

  modport slave (
    input  tx_flush, tx_wr, tx_din, tx_rd, tx_thr,
    input  rx_flush, rx_wr, rx_din, rx_rd, rx_thr, err_clr,
    output tx_dout, tx_empty, tx_full, tx_ocy, tx_low,
    output rx_dout, rx_empty, rx_full, rx_ocy, rx_high, err
  );
endinterface

// File: rtl/i2c_fifo_pair.sv
// rtl/i2c_fifo_pair.sv - FWFT TX/RX FIFO pair with flush, water marks and sticky errors
module i2c_fifo_pair_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   ocy,
  output logic          ovf,
  output logic          udf
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;

  assign empty = (ocy == '0);
  assign full  = (ocy == (AW+1)'(DEPTH));
  assign dout  = mem[rptr];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a simultaneous push.
  assign push = wr && (!full || rd) && !flush;
  assign pop  = rd && !empty && !flush;
  assign ovf  = wr && full && !rd && !flush;
  assign udf  = rd && empty && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      ocy  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      ocy  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   ocy <= ocy + 1'b1;
        2'b01:   ocy <= ocy - 1'b1;
        default: ocy <= ocy;
      endcase
    end
  end
endmodule

module i2c_fifo_pair #(
  parameter int TX_DW = 10,
  parameter int RX_DW = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  i2c_fifo_pair_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic tx_ovf, tx_udf, rx_ovf, rx_udf;
  logic [3:0] err_q;

  i2c_fifo_pair_fifo #(.DW(TX_DW), .DEPTH(DEPTH), .AW(AW)) u_tx (
    .clk(clk), .rst(rst), .flush(bus.tx_flush), .wr(bus.tx_wr), .din(bus.tx_din),
    .rd(bus.tx_rd), .dout(bus.tx_dout), .empty(bus.tx_empty), .full(bus.tx_full),
    .ocy(bus.tx_ocy), .ovf(tx_ovf), .udf(tx_udf)
  );

  i2c_fifo_pair_fifo #(.DW(RX_DW), .DEPTH(DEPTH), .AW(AW)) u_rx (
    .clk(clk), .rst(rst), .flush(bus.rx_flush), .wr(bus.rx_wr), .din(bus.rx_din),
    .rd(bus.rx_rd), .dout(bus.rx_dout), .empty(bus.rx_empty), .full(bus.rx_full),
    .ocy(bus.rx_ocy), .ovf(rx_ovf), .udf(rx_udf)
  );

  // Threshold outside 0..DEPTH naturally pins tx_low high and rx_high low.
  assign bus.tx_low  = (bus.tx_ocy <= bus.tx_thr);
  assign bus.rx_high = (bus.rx_thr != '0) && (bus.rx_ocy >= bus.rx_thr);
  assign bus.err     = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= (err_q & ~bus.err_clr) | {rx_udf, rx_ovf, tx_udf, tx_ovf};
    end
  end
endmodule

// File: tb/tb_i2c_fifo_pair.sv
// tb/tb_i2c_fifo_pair.sv - directed vector bench for i2c_fifo_pair
module tb_i2c_fifo_pair;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  i2c_fifo_pair_if #(.TX_DW(10), .RX_DW(8), .DEPTH(16)) bus ();
  i2c_fifo_pair #(.TX_DW(10), .RX_DW(8), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       tx_wr;
    logic       tx_rd;
    logic       tx_flush;
    logic [9:0] tx_din;
    logic       rx_wr;
    logic       rx_rd;
    logic       rx_flush;
    logic [7:0] rx_din;
    logic [3:0] err_clr;
    logic [4:0] tx_thr;
    logic [4:0] rx_thr;
    logic [4:0] e_tx_ocy;
    logic [9:0] e_tx_dout;
    logic [4:0] e_rx_ocy;
    logic [7:0] e_rx_dout;
    logic [3:0] e_err;
    logic       e_tx_low;
    logic       e_rx_high;
  } vec_t;

  vec_t vecs [16];
  logic [9:0] model [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.tx_wr = 0; bus.tx_rd = 0; bus.tx_flush = 0; bus.tx_din = '0;
    bus.rx_wr = 0; bus.rx_rd = 0; bus.rx_flush = 0; bus.rx_din = '0;
    bus.err_clr = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    bus.tx_thr = 5'd2;
    bus.rx_thr = 5'd4;

    //          txwr rd fl din     rxwr rd fl din    clr   txthr rxthr etx etxd    erx erxd   err  low high
    vecs[0]  = '{0, 0, 0, 10'h000, 1, 1, 0, 8'hA5, 4'h0, 5'd2, 5'd4, 0, 10'h000, 1, 8'hA5, 4'h8, 1, 0};
    vecs[1]  = '{0, 0, 0, 10'h000, 1, 0, 0, 8'h11, 4'h8, 5'd2, 5'd4, 0, 10'h000, 2, 8'hA5, 4'h0, 1, 0};
    vecs[2]  = '{0, 0, 0, 10'h000, 1, 0, 0, 8'h22, 4'h0, 5'd2, 5'd4, 0, 10'h000, 3, 8'hA5, 4'h0, 1, 0};
    vecs[3]  = '{0, 0, 0, 10'h000, 1, 0, 0, 8'h33, 4'h0, 5'd2, 5'd4, 0, 10'h000, 4, 8'hA5, 4'h0, 1, 1};
    vecs[4]  = '{0, 0, 0, 10'h000, 0, 1, 0, 8'h00, 4'h0, 5'd2, 5'd4, 0, 10'h000, 3, 8'h11, 4'h0, 1, 0};
    vecs[5]  = '{0, 1, 0, 10'h000, 0, 0, 0, 8'h00, 4'h0, 5'd2, 5'd4, 0, 10'h000, 3, 8'h11, 4'h2, 1, 0};
    vecs[6]  = '{1, 1, 0, 10'h155, 0, 0, 0, 8'h00, 4'h2, 5'd2, 5'd4, 1, 10'h155, 3, 8'h11, 4'h2, 1, 0};
    vecs[7]  = '{1, 0, 0, 10'h2AA, 0, 0, 0, 8'h00, 4'h2, 5'd2, 5'd4, 2, 10'h155, 3, 8'h11, 4'h0, 1, 0};
    vecs[8]  = '{1, 0, 0, 10'h0F0, 0, 0, 0, 8'h00, 4'h0, 5'd2, 5'd4, 3, 10'h155, 3, 8'h11, 4'h0, 0, 0};
    vecs[9]  = '{0, 1, 0, 10'h000, 0, 0, 0, 8'h00, 4'h0, 5'd2, 5'd4, 2, 10'h2AA, 3, 8'h11, 4'h0, 1, 0};
    vecs[10] = '{0, 0, 0, 10'h000, 1, 1, 1, 8'h44, 4'h0, 5'd2, 5'd4, 2, 10'h2AA, 0, 8'h00, 4'h0, 1, 0};
    vecs[11] = '{1, 1, 1, 10'h3FF, 0, 0, 0, 8'h00, 4'h0, 5'd2, 5'd4, 0, 10'h000, 0, 8'h00, 4'h0, 1, 0};
    vecs[12] = '{0, 0, 0, 10'h000, 1, 0, 0, 8'h77, 4'h0, 5'd20, 5'd0, 0, 10'h000, 1, 8'h77, 4'h0, 1, 0};
    vecs[13] = '{0, 0, 0, 10'h000, 0, 0, 0, 8'h00, 4'h0, 5'd20, 5'd1, 0, 10'h000, 1, 8'h77, 4'h0, 1, 1};
    vecs[14] = '{0, 0, 0, 10'h000, 0, 0, 0, 8'h00, 4'h0, 5'd0, 5'd17, 0, 10'h000, 1, 8'h77, 4'h0, 1, 0};
    vecs[15] = '{1, 0, 0, 10'h001, 1, 0, 0, 8'h88, 4'h0, 5'd0, 5'd17, 1, 10'h001, 2, 8'h77, 4'h0, 0, 0};

    // Reset state while rst is held
    #2;
    chk("rst_tx_empty", 32'(bus.tx_empty), 32'd1);
    chk("rst_tx_full",  32'(bus.tx_full),  32'd0);
    chk("rst_tx_ocy",   32'(bus.tx_ocy),   32'd0);
    chk("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
    chk("rst_err",      32'(bus.err),      32'd0);
    chk("rst_tx_low",   32'(bus.tx_low),   32'd1);
    chk("rst_rx_high",  32'(bus.rx_high),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      bus.tx_wr = vecs[i].tx_wr; bus.tx_rd = vecs[i].tx_rd;
      bus.tx_flush = vecs[i].tx_flush; bus.tx_din = vecs[i].tx_din;
      bus.rx_wr = vecs[i].rx_wr; bus.rx_rd = vecs[i].rx_rd;
      bus.rx_flush = vecs[i].rx_flush; bus.rx_din = vecs[i].rx_din;
      bus.err_clr = vecs[i].err_clr;
      bus.tx_thr = vecs[i].tx_thr; bus.rx_thr = vecs[i].rx_thr;
      cyc();
      idle();
      chk($sformatf("v%0d_tx_ocy", i), 32'(bus.tx_ocy), 32'(vecs[i].e_tx_ocy));
      chk($sformatf("v%0d_rx_ocy", i), 32'(bus.rx_ocy), 32'(vecs[i].e_rx_ocy));
      chk($sformatf("v%0d_err", i), 32'(bus.err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_tx_low", i), 32'(bus.tx_low), 32'(vecs[i].e_tx_low));
      chk($sformatf("v%0d_rx_high", i), 32'(bus.rx_high), 32'(vecs[i].e_rx_high));
      if (vecs[i].e_tx_ocy != 0)
        chk($sformatf("v%0d_tx_dout", i), 32'(bus.tx_dout), 32'(vecs[i].e_tx_dout));
      if (vecs[i].e_rx_ocy != 0)
        chk($sformatf("v%0d_rx_dout", i), 32'(bus.rx_dout), 32'(vecs[i].e_rx_dout));
    end

    // Fill TX, overflow, simultaneous push/pop at full across pointer wrap, then drain
    bus.tx_thr = 5'd2; bus.rx_thr = 5'd4;
    bus.tx_flush = 1; bus.rx_flush = 1; bus.err_clr = 4'hF;
    cyc();
    idle();
    for (int i = 0; i < 16; i++) begin
      bus.tx_wr = 1; bus.tx_din = 10'(i);
      model.push_back(10'(i));
      cyc();
    end
    idle();
    chk("fill_full", 32'(bus.tx_full), 32'd1);
    chk("fill_ocy",  32'(bus.tx_ocy),  32'd16);
    chk("fill_head", 32'(bus.tx_dout), 32'h000);

    bus.tx_wr = 1; bus.tx_din = 10'h3FF;
    cyc();
    idle();
    chk("ovf_ocy",  32'(bus.tx_ocy),  32'd16);
    chk("ovf_err",  32'(bus.err),     32'h1);
    chk("ovf_head", 32'(bus.tx_dout), 32'h000);
    bus.err_clr = 4'b0001;
    cyc();
    idle();
    chk("ovf_clr", 32'(bus.err), 32'h0);

    for (int i = 0; i < 32; i++) begin
      chk($sformatf("wrap%0d_dout", i), 32'(bus.tx_dout), 32'(model[0]));
      bus.tx_wr = 1; bus.tx_rd = 1; bus.tx_din = 10'(10'h100 + i);
      void'(model.pop_front());
      model.push_back(10'(10'h100 + i));
      cyc();
      chk($sformatf("wrap%0d_ocy", i), 32'(bus.tx_ocy), 32'd16);
    end
    idle();
    chk("wrap_err", 32'(bus.err), 32'h0);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_dout", i), 32'(bus.tx_dout), 32'(model[0]));
      bus.tx_rd = 1;
      void'(model.pop_front());
      cyc();
    end
    idle();
    chk("drain_empty", 32'(bus.tx_empty), 32'd1);
    chk("drain_ocy",   32'(bus.tx_ocy),   32'd0);
    chk("drain_err",   32'(bus.err),      32'h0);

    // Low-water crossing, then asynchronous reset with data queued
    for (int i = 0; i < 5; i++) begin
      bus.tx_wr = 1; bus.tx_din = 10'(10'h040 + i);
      cyc();
    end
    idle();
    chk("lw_ocy5", 32'(bus.tx_ocy), 32'd5);
    chk("lw_low5", 32'(bus.tx_low), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.tx_rd = 1;
      cyc();
      idle();
      chk($sformatf("lw_dout%0d", i), 32'(bus.tx_dout), 32'(10'h041 + i));
      chk($sformatf("lw_low%0d", 4 - i), 32'(bus.tx_low), (i == 2) ? 32'd1 : 32'd0);
    end
    chk("lw_ocy2", 32'(bus.tx_ocy), 32'd2);
    for (int i = 0; i < 3; i++) begin
      bus.tx_wr = 1; bus.tx_din = 10'(10'h050 + i);
      bus.rx_wr = 1; bus.rx_din = 8'(8'hC0 + i);
      cyc();
    end
    idle();
    chk("pre_rst_ocy", 32'(bus.tx_ocy), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_ocy",   32'(bus.tx_ocy),   32'd0);
    chk("arst_tx_empty", 32'(bus.tx_empty), 32'd1);
    chk("arst_rx_ocy",   32'(bus.rx_ocy),   32'd0);
    chk("arst_tx_low",   32'(bus.tx_low),   32'd1);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("post_rst_ocy", 32'(bus.tx_ocy), 32'd0);
    chk("post_rst_err", 32'(bus.err),    32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
